// File: rtl/csa_pkg.sv
// Shared defaults and the operand-pair type used by the
// adder issue path and its surroundings.
package csa_pkg;

  localparam int N_DEF   = 32;
  localparam int LAT_DEF = 2;
  localparam int CNT_W   = 16;

  typedef struct packed {
    logic [N_DEF-1:0] a;
    logic [N_DEF-1:0] b;
  } pair_t;

endpackage

// File: rtl/carry_save_adder_pipeline.sv
// Pipelined adder: operands reduced to sum/carry form on entry,
// carried LAT stages, resolved to a binary sum at the output.
// Ports: clk, A, B in; sum out (LAT edges after A/B change).
module carry_save_adder_pipeline #(
  parameter int n   = 32,
  parameter int LAT = 2
) (
  input  logic         clk,
  input  logic [n-1:0] A,
  input  logic [n-1:0] B,
  output logic [n-1:0] sum
);

  logic [n-1:0] s_q [LAT];
  logic [n-1:0] c_q [LAT];

  // Top carry bit falls off: result is mod 2^n.
  always_ff @(posedge clk) begin
    s_q[0] <= A ^ B;
    c_q[0] <= {A[n-2:0] & B[n-2:0], 1'b0};
    for (int i = 1; i < LAT; i++) begin
      s_q[i] <= s_q[i-1];
      c_q[i] <= c_q[i-1];
    end
  end

  assign sum = s_q[LAT-1] + c_q[LAT-1];

endmodule

// File: rtl/csa_operand_fifo.sv
// Synchronous FIFO for packed operand pairs.
// Ports: clk, reset, push_i/wdata_i, pop_i/rdata_o, full_o, empty_o.
module csa_operand_fifo #(
  parameter int W     = 64,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push_i,
  input  logic [W-1:0] wdata_i,
  input  logic         pop_i,
  output logic [W-1:0] rdata_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          do_push, do_pop;

  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign rdata_o = mem_q[rptr_q];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (do_push) wptr_d = wptr_q + 1'b1;
    if (do_pop)  rptr_d = rptr_q + 1'b1;
    unique case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  // Storage needs no reset: occupancy gates every read.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= wdata_i;
  end

endmodule

// File: rtl/csa_operand_issue.sv
// Operand issue stage: buffers pairs, drives the adder, tags results.
// Ports: in_* handshake, issue_en, A/B out, sum_in, out_*, busy, issue_cnt.
module csa_operand_issue
  import csa_pkg::*;
#(
  parameter int n     = N_DEF,
  parameter int DEPTH = 4,
  parameter int LAT   = LAT_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [n-1:0]     in_a,
  input  logic [n-1:0]     in_b,
  input  logic             issue_en,
  output logic [n-1:0]     A,
  output logic [n-1:0]     B,
  input  logic [n-1:0]     sum_in,
  output logic             out_valid,
  output logic [n-1:0]     out_sum,
  output logic             busy,
  output logic [CNT_W-1:0] issue_cnt
);

  logic [2*n-1:0]   head;
  logic             full, empty;
  logic             push, pop;

  logic [n-1:0]     a_q, a_d;
  logic [n-1:0]     b_q, b_d;
  logic             iss_v_q, iss_v_d;
  logic [LAT-1:0]   tag_q, tag_d;
  logic             ov_q, ov_d;
  logic [n-1:0]     os_q, os_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign in_ready = !full;
  assign push     = in_valid && !full;
  assign pop      = issue_en && !empty;

  csa_operand_fifo #(
    .W     (2*n),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push),
    .wdata_i ({in_a, in_b}),
    .pop_i   (pop),
    .rdata_o (head),
    .full_o  (full),
    .empty_o (empty)
  );

  always_comb begin
    a_d     = '0;
    b_d     = '0;
    iss_v_d = 1'b0;
    cnt_d   = cnt_q;
    if (pop) begin
      a_d     = head[2*n-1:n];
      b_d     = head[n-1:0];
      iss_v_d = 1'b1;
      cnt_d   = cnt_q + 1'b1;
    end
    // tag[LAT-1] marks the cycle sum_in belongs to a real pair.
    tag_d = (tag_q << 1) | LAT'(iss_v_q);
    ov_d  = tag_q[LAT-1];
    os_d  = tag_q[LAT-1] ? sum_in : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_q     <= '0;
      b_q     <= '0;
      iss_v_q <= 1'b0;
      tag_q   <= '0;
      ov_q    <= 1'b0;
      os_q    <= '0;
      cnt_q   <= '0;
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      iss_v_q <= iss_v_d;
      tag_q   <= tag_d;
      ov_q    <= ov_d;
      os_q    <= os_d;
      cnt_q   <= cnt_d;
    end
  end

  assign A         = a_q;
  assign B         = b_q;
  assign out_valid = ov_q;
  assign out_sum   = os_q;
  assign issue_cnt = cnt_q;
  assign busy      = !empty || iss_v_q || (|tag_q) || ov_q;

endmodule
